// File: rtl/booth_pkg.sv
// Shared constants and types for the multiplier result path.
// Sizes the BCD converter for the 16-bit Booth product by default.
package booth_pkg;

  localparam int RESULT_W      = 16;
  localparam int RESULT_DIGITS = 5;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } bcd_state_t;

  // Bit-counter width for a WIDTH-bit conversion (counts 0..WIDTH-1).
  function automatic int bcd_cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  localparam int RESULT_CNT_W = bcd_cnt_w(RESULT_W);

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_digit_adjust (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/result_bcd_converter.sv
// Sequential two's-complement to BCD converter (one bit per clock) producing
// sign, magnitude digits and a leading-zero blanking mask for the display.
module result_bcd_converter
  import booth_pkg::*;
#(
  parameter int WIDTH  = RESULT_W,
  parameter int DIGITS = RESULT_DIGITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    value,
  output logic                busy,
  output logic                done,
  output logic                sign,
  output logic [4*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]   digit_en
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SH_W  = BCD_W + WIDTH;
  localparam int CNT_W = bcd_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  bcd_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SH_W-1:0]   shift_q, shift_d;
  logic              sign_pend_q, sign_pend_d;
  logic              done_q, done_d;
  logic              sign_q, sign_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [DIGITS-1:0] en_q, en_d;

  logic [WIDTH-1:0]  mag;
  logic [BCD_W-1:0]  adj;
  logic [SH_W-1:0]   shifted;
  logic [BCD_W-1:0]  next_bcd;
  logic [DIGITS-1:0] next_en;
  logic              any_nz;

  // -2^(WIDTH-1) negates to itself, which read unsigned is the exact magnitude.
  assign mag = value[WIDTH-1] ? (~value + 1'b1) : value;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (shift_q[WIDTH + 4*g +: 4]),
      .digit_o (adj[4*g +: 4])
    );
  end

  assign shifted  = {adj[BCD_W-2:0], shift_q[WIDTH-1:0], 1'b0};
  assign next_bcd = shifted[SH_W-1 -: BCD_W];

  // A digit is lit if it or any more significant digit is nonzero.
  always_comb begin
    any_nz  = 1'b0;
    next_en = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      any_nz     = any_nz | (|next_bcd[4*i +: 4]);
      next_en[i] = any_nz;
    end
    next_en[0] = 1'b1;
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    sign_pend_d = sign_pend_q;
    done_d      = 1'b0;
    sign_d      = sign_q;
    bcd_d       = bcd_q;
    en_d        = en_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sign_pend_d = value[WIDTH-1];
          shift_d     = {{BCD_W{1'b0}}, mag};
          cnt_d       = '0;
          state_d     = CONVERT;
        end
      end
      CONVERT: begin
        shift_d = shifted;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          bcd_d   = next_bcd;
          sign_d  = sign_pend_q;
          en_d    = next_en;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      sign_pend_q <= 1'b0;
      done_q      <= 1'b0;
      sign_q      <= 1'b0;
      bcd_q       <= '0;
      en_q        <= DIGITS'(1);
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      sign_pend_q <= sign_pend_d;
      done_q      <= done_d;
      sign_q      <= sign_d;
      bcd_q       <= bcd_d;
      en_q        <= en_d;
    end
  end

  assign busy     = (state_q == CONVERT);
  assign done     = done_q;
  assign sign     = sign_q;
  assign bcd      = bcd_q;
  assign digit_en = en_q;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Directed-vector bench for result_bcd_converter: one task per scenario,
// inputs driven and outputs sampled on the falling clock edge.
module tb_result_bcd_converter;
  import booth_pkg::*;

  localparam int W = RESULT_W;
  localparam int D = RESULT_DIGITS;
  // Negedges from driving start until done is seen: accept edge + 16 shift edges.
  localparam int DONE_NEG = W + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   value = '0;
  logic           busy, done, sign;
  logic [4*D-1:0] bcd;
  logic [D-1:0]   digit_en;

  int total = 0;
  int bad   = 0;

  result_bcd_converter #(.WIDTH(W), .DIGITS(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .value    (value),
    .busy     (busy),
    .done     (done),
    .sign     (sign),
    .bcd      (bcd),
    .digit_en (digit_en)
  );

  always #5 clk = ~clk;

  // Waits (bounded) for done; cycles stays -1 if it never comes.
  task automatic wait_done(output int cycles, output int busy_cycles, output bit overlap);
    cycles = -1; busy_cycles = 0; overlap = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy && done) overlap = 1'b1;
      if (busy) busy_cycles++;
      if (done) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic launch(input logic [W-1:0] v);
    @(negedge clk);
    value = v;
    start = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; value = '0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (sign !== 1'b0) begin bad++; $display("FAIL reset_sign got=%b want=0", sign); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (bcd !== 20'h00000) begin bad++; $display("FAIL reset_bcd got=%h want=00000", bcd); end
    total++; if (digit_en !== 5'b00001) begin bad++; $display("FAIL reset_en got=%b want=00001", digit_en); end
  endtask

  task automatic run_case(input string name, input logic [W-1:0] v, input logic exp_sign,
                          input logic [4*D-1:0] exp_bcd, input logic [D-1:0] exp_en);
    int cyc, bcyc; bit ov;
    launch(v);
    wait_done(cyc, bcyc, ov);
    total++; if (cyc !== DONE_NEG) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, cyc, DONE_NEG); end
    total++; if (bcyc !== W) begin bad++; $display("FAIL %s_busy_cycles got=%0d want=%0d", name, bcyc, W); end
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL %s_busy_done_overlap got=1 want=0", name); end
    total++; if (sign !== exp_sign) begin bad++; $display("FAIL %s_sign got=%b want=%b", name, sign, exp_sign); end
    total++; if (bcd !== exp_bcd) begin bad++; $display("FAIL %s_bcd got=%h want=%h", name, bcd, exp_bcd); end
    total++; if (digit_en !== exp_en) begin bad++; $display("FAIL %s_en got=%b want=%b", name, digit_en, exp_en); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL %s_done_pulse_width got=1 want=0", name); end
    total++; if (bcd !== exp_bcd) begin bad++; $display("FAIL %s_bcd_hold got=%h want=%h", name, bcd, exp_bcd); end
  endtask

  task automatic test_values;
    run_case("zero",    16'd0,     1'b0, 20'h00000, 5'b00001);
    run_case("prod127", 16'd16129, 1'b0, 20'h16129, 5'b11111);
    run_case("neg1",    16'hFFFF,  1'b1, 20'h00001, 5'b00001);
    run_case("min",     16'h8000,  1'b1, 20'h32768, 5'b11111);
  endtask

  task automatic test_back_to_back;
    int cyc, bcyc; bit ov;
    launch(16'hFF80);
    wait_done(cyc, bcyc, ov);
    total++; if (cyc !== DONE_NEG) begin bad++; $display("FAIL b2b_first_latency got=%0d want=%0d", cyc, DONE_NEG); end
    total++; if ({sign, bcd, digit_en} !== {1'b1, 20'h00128, 5'b00111}) begin
      bad++; $display("FAIL b2b_first got=%b/%h/%b want=1/00128/00111", sign, bcd, digit_en);
    end
    // Start again in the done cycle; next done should be 17 cycles on.
    value = 16'd5;
    start = 1'b1;
    wait_done(cyc, bcyc, ov);
    total++; if (cyc !== W + 1) begin bad++; $display("FAIL b2b_second_spacing got=%0d want=%0d", cyc, W + 1); end
    total++; if ({sign, bcd, digit_en} !== {1'b0, 20'h00005, 5'b00001}) begin
      bad++; $display("FAIL b2b_second got=%b/%h/%b want=0/00005/00001", sign, bcd, digit_en);
    end
  endtask

  task automatic test_start_while_busy;
    int cyc = -1;
    launch(16'd999);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 5) begin
        start = 1'b1;
        value = 16'd1;
      end
      if (done) begin
        cyc = i;
        break;
      end
    end
    total++; if (cyc !== DONE_NEG) begin bad++; $display("FAIL busy_start_latency got=%0d want=%0d", cyc, DONE_NEG); end
    total++; if ({sign, bcd, digit_en} !== {1'b0, 20'h00999, 5'b00111}) begin
      bad++; $display("FAIL busy_start_result got=%b/%h/%b want=0/00999/00111", sign, bcd, digit_en);
    end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_start_no_queue got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid;
    bit saw_done = 1'b0;
    launch(16'd999);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b0;
    #1;
    total++; if ({busy, done, sign} !== 3'b000) begin
      bad++; $display("FAIL rst_mid_flags got=%b%b%b want=000", busy, done, sign);
    end
    total++; if (bcd !== 20'h00000) begin bad++; $display("FAIL rst_mid_bcd got=%h want=00000", bcd); end
    total++; if (digit_en !== 5'b00001) begin bad++; $display("FAIL rst_mid_en got=%b want=00001", digit_en); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL rst_mid_no_done got=1 want=0"); end
    total++; if (bcd !== 20'h00000) begin bad++; $display("FAIL rst_mid_bcd_after got=%h want=00000", bcd); end
  endtask

  initial begin
    test_reset;
    test_values;
    test_back_to_back;
    test_start_while_busy;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_bcd_converter.md
# result_bcd_converter

Sequential binary-to-BCD converter for the multiplier result path: accepts a two's-complement product and produces sign, decimal digits and a leading-zero blanking mask for the display driver. It performs the inverse of the keypad path, which builds binary operands from decimal digits. Conversion uses shift-and-add-3 (double dabble), one bit per clock. It sits between the Booth multiplier output and the seven-segment display mux.

## Interface

Parameters:

- WIDTH, 16, bit width of the signed input value.
- DIGITS, 5, number of BCD output digits. Requires 10^DIGITS > 2^(WIDTH-1).

Ports:

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request conversion of `value`; sampled only in IDLE.
- value  in  WIDTH  two's-complement number to convert.
- busy  out  1  high while a conversion is in progress.
- done  out  1  single-cycle pulse when new results are valid.
- sign  out  1  1 when the converted value was negative.
- bcd  out  4*DIGITS  magnitude digits; bcd[3:0] is units, bcd[4*DIGITS-1 -: 4] is the most significant digit.
- digit_en  out  DIGITS  per-digit display enable with leading zeros blanked. Bit 0 is always 1.

## Operation

- States: IDLE and CONVERT.
- **IDLE**
  - When start=1 at an edge, capture `sign_q = value[WIDTH-1]` and `mag = |value|`. The magnitude is WIDTH bits unsigned, so -2^(WIDTH-1) yields 2^(WIDTH-1) exactly.
  - On the same edge, clear the scratch BCD register, set bit counter = 0, and go to CONVERT.
- **CONVERT**, once per edge:
  - Apply add-3 to every scratch digit ≥ 5.
  - Shift {scratch, mag} left by one.
  - Increment the counter.
  - On the edge where the counter reaches WIDTH-1 (the WIDTH-th shift):
    - Load the outputs `bcd` from the shifted scratch value.
    - Load `sign` from sign_q.
    - Compute and load `digit_en`.
    - Assert `done`.
    - Return to IDLE.
- **digit_en rule:** bit i = 1 if any digit j ≥ i is nonzero, or if i = 0.
- **Output holding:** `bcd`, `sign` and `digit_en` hold their last values until the next completion. They never show intermediate scratch contents.
- **Zero:** -0 does not exist; value 0 gives sign=0.
- **start while busy:** ignored, with no queuing. The in-flight conversion is unaffected.

## Timing

- Reset values:
  - busy=0, done=0, sign=0, bcd=0.
  - digit_en = DIGITS'b1 (units only).
  - State IDLE, scratch and counter cleared.
- Latency:
  - start accepted at edge 0.
  - busy is high from after edge 0 through edge WIDTH.
  - done is high for exactly the one cycle following edge WIDTH, which is 16 cycles for the default WIDTH.
- busy and done are never high in the same cycle.
- Back-to-back conversions:
  - The state is IDLE during the done cycle, so start=1 in that cycle is accepted.
  - Throughput is one conversion per WIDTH+1 cycles.
- `value` is sampled only at the accepting edge. Later changes have no effect on the conversion.
- Reset mid-conversion:
  - Immediately clears all registers to reset values.
  - No done pulse is produced.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure

- Shared package `booth_pkg`:
  - RESULT_W = 16
  - RESULT_DIGITS = 5
  - State enum `bcd_state_t` {IDLE, CONVERT}
  - Counter width constant $clog2(WIDTH)
- Sub-module `bcd_digit_adjust`:
  - Combinational 4-bit in, 4-bit out.
  - Adds 3 when the input is ≥ 5.
  - Instantiated DIGITS times via generate.
- Top module holds:
  - the FSM
  - the shift register of DIGITS*4 + WIDTH bits
  - the counter
  - the output registers

## Test plan

- Reset, then start with value=0:
  - Before conversion: digit_en=00001, bcd=0.
  - After conversion: done after 16 cycles, sign=0, bcd=0x00000, digit_en=00001.
- value=16'd16129 (127×127):
  - bcd=0x16129, sign=0, digit_en=11111.
  - busy high exactly 16 cycles.
- value=16'hFFFF (-1): sign=1, bcd=0x00001, digit_en=00001.
- value=16'h8000 (-32768): sign=1, bcd=0x32768, digit_en=11111.
- value=16'hFF80 (-128):
  - sign=1, bcd=0x00128, digit_en=00111.
  - Assert start again (value=5) in the done cycle: second done 17 cycles later with bcd=0x00005.
- Start a conversion of 999:
  - Pulse start with value=1 at cycle 5: ignored, result bcd=0x00999.
  - Repeat the conversion and drop rst at cycle 8: all outputs go to reset values, with no done pulse.
